// File: rtl/fosfor_present_core.sv
// Iterative PRESENT encryption core: one round per clock, 80- or 128-bit key
// schedule, configurable round count and a one-cycle completion pulse.
module fosfor_present_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             Clk_k,
  input  logic             Reset_r,
  input  logic             Start,
  input  logic [KEY_W-1:0] Key_b,
  input  logic [63:0]      PlainText_b,
  output logic [63:0]      CipherText_b,
  output logic             Ready,
  output logic             Done
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("fosfor_present_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("fosfor_present_core: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [63:0]      state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [63:0]      ct_d;
  logic             ready_d, done_d;

  logic [63:0]      round_key;
  logic [63:0]      sbox_out;
  logic [63:0]      perm_out;
  logic [KEY_W-1:0] key_rot;
  logic [KEY_W-1:0] key_upd;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  assign round_key = key_q[KEY_W-1 -: 64];

  always_comb begin
    sbox_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sbox_out[4*i +: 4] = sbox(state_q[4*i +: 4] ^ round_key[4*i +: 4]);
    end
  end

  always_comb begin
    perm_out = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      perm_out[(16*j) % 63] = sbox_out[j];
    end
    perm_out[63] = sbox_out[63];
  end

  // Rotate left by 61 == move the low KEY_W-61 bits to the top.
  assign key_rot = {key_q[KEY_W-62:0], key_q[KEY_W-1:KEY_W-61]};

  if (KEY_W == 128) begin : g_key128
    always_comb begin
      key_upd          = key_rot;
      key_upd[127:124] = sbox(key_rot[127:124]);
      key_upd[123:120] = sbox(key_rot[123:120]);
      key_upd[66:62]   = key_rot[66:62] ^ cnt_q;
    end
  end else begin : g_key80
    always_comb begin
      key_upd        = key_rot;
      key_upd[79:76] = sbox(key_rot[79:76]);
      key_upd[19:15] = key_rot[19:15] ^ cnt_q;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    ct_d    = CipherText_b;
    ready_d = Ready;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (Start) begin
          state_d = PlainText_b;
          key_d   = Key_b;
          cnt_d   = 5'd1;
          ready_d = 1'b0;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = perm_out;
        key_d   = key_upd;
        if (cnt_q == LAST_ROUND) begin
          fsm_d = FINAL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      FINAL: begin
        ct_d    = state_q ^ round_key;
        ready_d = 1'b1;
        done_d  = 1'b1;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_k or posedge Reset_r) begin
    if (Reset_r) begin
      fsm_q        <= IDLE;
      state_q      <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      CipherText_b <= '0;
      Ready        <= 1'b1;
      Done         <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      CipherText_b <= ct_d;
      Ready        <= ready_d;
      Done         <= done_d;
    end
  end

endmodule

// File: doc/fosfor_present_core.md
# fosfor_present_core

Parametrised, iterative PRESENT block-cipher encryption core, one round per clock. It replaces the fixed 80-bit/31-round datapath behind the nibble host bus of `fosfor_present_top`. It adds a 128-bit key schedule, a configurable round count for reduced-round characterisation, and a one-cycle completion pulse. The core sits between the host register file (key/plaintext/ciphertext bytes, status bit 0 = ready) and the command decoder, which drives `Start`.

## Interface
Parameters:
- `KEY_W`, default 80. Key width; legal values 80 or 128. Any other value is an elaboration error.
- `ROUNDS`, default 31. Number of full rounds; legal range 1..31. The round counter is 5 bits.

Ports (clock and reset first):
- `Clk_k`  in  1  single clock for the whole core.
- `Reset_r`  in  1  reset, asynchronous, active-high.
- `Start`  in  1  start request, sampled on the rising edge of `Clk_k`.
- `Key_b`  in  KEY_W  cipher key; bit KEY_W-1 is the MSB of the PRESENT key register.
- `PlainText_b`  in  64  plaintext block.
- `CipherText_b`  out  64  ciphertext, registered.
- `Ready`  out  1  core idle and able to accept `Start`; maps to status bit 0.
- `Done`  out  1  one-cycle pulse when a new `CipherText_b` is valid.

## Operation
- Reset values: FSM = IDLE, `Ready` = 1, `Done` = 0, `CipherText_b` = 0, round counter = 0, state and key registers = 0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - If `Start` = 1, load state ← `PlainText_b`, key ← `Key_b`, counter ← 1. Deassert `Ready` and go to ROUND.
  - `Key_b` and `PlainText_b` are sampled only at this edge; later changes have no effect.
- ROUND, with counter i:
  - Round key K_i = key[KEY_W-1 -: 64].
  - state ← pLayer(sBoxLayer(state XOR K_i)).
  - key ← update(key, i).
  - If i = ROUNDS, go to FINAL; otherwise counter ← i+1.
- update() for KEY_W = 80:
  - Rotate left by 61.
  - Replace bits [79:76] with S(bits [79:76]).
  - XOR bits [19:15] with i[4:0].
- update() for KEY_W = 128:
  - Rotate left by 61.
  - Replace bits [127:124] and [123:120] each with S() of themselves.
  - XOR bits [66:62] with i[4:0].
- S-box, input nibble 0..F maps to: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit j moves to position (16·j) mod 63 for j = 0..62; bit 63 stays at 63.
- FINAL:
  - `CipherText_b` ← state XOR key[KEY_W-1 -: 64].
  - `Ready` ← 1, `Done` ← 1 for exactly one cycle.
  - Return to IDLE.
- `Start` asserted while `Ready` = 0 is ignored. There is no queueing and no restart.
- `CipherText_b` holds its last value through a following operation until that operation's FINAL edge. It is never cleared by `Start`.
- Reset asserted mid-operation immediately forces all reset values. The partial result is discarded. `CipherText_b` returns to 0.

## Timing
- Start at edge E0:
  - `Ready` is low from E0 until E(ROUNDS+1).
  - Rounds execute on edges E1..E(ROUNDS).
  - FINAL executes on edge E(ROUNDS+1).
- Start-to-ready latency is ROUNDS+1 cycles; 32 cycles at the default (320 ns at 10 ns clock).
- `Done` is high for the single cycle after E(ROUNDS+1). `CipherText_b` is valid from that same cycle.
- `Start` held high continuously starts back-to-back operations. The next one is accepted on the edge after FINAL, because `Ready` = 1 in IDLE. Throughput is one block per ROUNDS+2 cycles.
- Counter wrap: the counter never exceeds ROUNDS. It is 5 bits wide, so ROUNDS = 31 reaches 31 without overflow.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- KEY_W=80, ROUNDS=31, key 0, plaintext 0, pulse `Start` → `Ready` = 0 the next cycle; `Done` pulse exactly 32 cycles after Start; `CipherText_b` = 5579C1387B228445.
- KEY_W=80: key FFFFFFFFFFFFFFFFFFFF with plaintext 0 → E72C46C0F5945049. Key 0 with plaintext FFFFFFFFFFFFFFFF → A112FFC72F68417B. Both all-F → 3333DCD3213210D2.
- KEY_W=128, key 0, plaintext 0 → 96DB702A2E6900AF after 32 cycles.
- Change `Key_b` and `PlainText_b` and pulse `Start` again in cycle 10 of an 80-bit all-zero run → no effect on the run; result is still 5579C1387B228445; `Ready` stays 0 until cycle 32.
- Assert `Reset_r` in cycle 15 of a run, then rerun with key 0, plaintext 0 → `Ready` = 1, `Done` = 0, `CipherText_b` = 0 immediately on reset; the rerun gives 5579C1387B228445 in 32 cycles.
- ROUNDS=1, KEY_W=80, key 0, plaintext 0 → `Done` 2 cycles after Start. Bench compares against a reference model, and checks that `Start` held high gives `Done` every 3 cycles.
